// File: rtl/sample_capture.sv
// AV-ST sample sink: captures a programmed number of bytes into a circular FIFO, drained over AXI-Lite.
// Optional macro CAPTURE_PACK_EN packs up to four samples into each DATA read.
module sample_capture #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LENGTH_W   = 16
) (
    input  logic        S_AXI_ACLK,
    input  logic        rst_sys,
    input  logic        S_AVST_VALID,
    input  logic [7:0]  S_AVST_DATA,
    output logic        S_AVST_READY,
    output logic        M_AVST_VALID,
    output logic [7:0]  M_AVST_DATA,
    input  logic        M_AVST_READY,
    input  logic [3:0]  S_AXI_AWADDR,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [3:0]  S_AXI_ARADDR,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [1:0] WRRESET = 2'd0, WRIDLE = 2'd1, WRDATA = 2'd2, WRRESP = 2'd3;
    localparam logic [1:0] RDRESET = 2'd0, RDIDLE = 2'd1, RDDATA = 2'd2;
    localparam logic [1:0] IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2;

    logic [1:0]            wstate, rstate, state;
    logic [3:0]            waddr;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic [CW-1:0]         count, pop_n;
    logic                  overflow, start_beat, full, empty;
    logic [LENGTH_W-1:0]   length, cap_cnt, lane_mask;
    logic [31:0]           rdata, rd_next, data_word;
    logic                  w_fire, ctrl_wr, arm, clear, len_wr, ar_fire, data_rd;
    logic                  push, pop, ovf_evt;
    logic                  unused_bits;

    assign unused_bits = ^{M_AVST_READY, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WDATA, S_AXI_WSTRB};

    assign S_AXI_AWREADY = (wstate == WRIDLE);
    assign S_AXI_WREADY  = (wstate == WRDATA);
    assign S_AXI_BVALID  = (wstate == WRRESP);
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = (rstate == RDIDLE);
    assign S_AXI_RVALID  = (rstate == RDDATA);
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RDATA   = rdata;
    assign M_AVST_VALID  = start_beat;
    assign M_AVST_DATA   = start_beat ? 8'h01 : 8'h00;

    assign w_fire  = S_AXI_WVALID && (wstate == WRDATA);
    assign ctrl_wr = w_fire && (waddr == 4'h0) && S_AXI_WSTRB[0];
    assign clear   = ctrl_wr && S_AXI_WDATA[1];
    assign arm     = ctrl_wr && S_AXI_WDATA[0];
    assign len_wr  = w_fire && (waddr == 4'h4);
    assign ar_fire = S_AXI_ARVALID && (rstate == RDIDLE);
    assign data_rd = ar_fire && (S_AXI_ARADDR == 4'hC);
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < LENGTH_W; i++) lane_mask[i] = S_AXI_WSTRB[i / 8];
    end

`ifdef CAPTURE_PACK_EN
    localparam logic [CW-1:0] FOUR = CW'(4);
    always_comb begin
        data_word = '0;
        for (int i = 0; i < 4; i++)
            if (count > CW'(i)) data_word[8*i +: 8] = mem[rptr + DEPTH_LOG2'(i)];
        pop_n = '0;
        if (data_rd && !clear) pop_n = (count > FOUR) ? FOUR : count;
    end
`else
    always_comb begin
        data_word = empty ? 32'h0 : {24'h0, mem[rptr]};
        pop_n     = (data_rd && !empty && !clear) ? ONE : '0;
    end
`endif

    // A same-cycle pop frees a slot, so a full FIFO may still accept.
    assign pop          = (pop_n != '0);
    assign S_AVST_READY = (state == CAPTURE) && (!full || pop) && !clear;
    assign push         = S_AVST_VALID && S_AVST_READY;
    assign ovf_evt      = (state == CAPTURE) && S_AVST_VALID && full && !pop && !clear;

    always_comb begin
        case (S_AXI_ARADDR)
            4'h4:    rd_next = 32'(length);
            4'h8:    rd_next = {11'h0, overflow, empty, full, state, 16'(count)};
            4'hC:    rd_next = data_word;
            default: rd_next = 32'h0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (push) mem[wptr] <= S_AVST_DATA;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (rst_sys) begin
            wstate     <= WRRESET;
            rstate     <= RDRESET;
            state      <= IDLE;
            waddr      <= '0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            length     <= '0;
            cap_cnt    <= '0;
            start_beat <= 1'b0;
            rdata      <= '0;
        end else begin
            case (wstate)
                WRRESET: wstate <= WRIDLE;
                WRIDLE:  if (S_AXI_AWVALID) begin wstate <= WRDATA; waddr <= S_AXI_AWADDR; end
                WRDATA:  if (S_AXI_WVALID) wstate <= WRRESP;
                default: if (S_AXI_BREADY) wstate <= WRIDLE;
            endcase
            case (rstate)
                RDRESET: rstate <= RDIDLE;
                RDIDLE:  if (S_AXI_ARVALID) rstate <= RDDATA;
                default: if (S_AXI_RREADY) rstate <= RDIDLE;
            endcase
            if (ar_fire) rdata <= rd_next;
            if (len_wr) length <= (length & ~lane_mask) | (S_AXI_WDATA[LENGTH_W-1:0] & lane_mask);
            start_beat <= 1'b0;
            if (clear) begin
                state    <= IDLE;
                wptr     <= '0;
                rptr     <= '0;
                count    <= '0;
                overflow <= 1'b0;
                cap_cnt  <= '0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop) rptr <= rptr + DEPTH_LOG2'(pop_n);
                count <= count + (push ? ONE : '0) - pop_n;
                if (ovf_evt) overflow <= 1'b1;
                case (state)
                    CAPTURE: if (push) begin
                        cap_cnt <= cap_cnt + LENGTH_W'(1);
                        if (cap_cnt + LENGTH_W'(1) == length) state <= DONE;
                    end
                    default: if (arm && length != '0) begin
                        state      <= CAPTURE;
                        cap_cnt    <= '0;
                        start_beat <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule
